// File: rtl/uart_pkg.sv
// Shared UART definitions: frame format, state encoding and rate defaults.
// Imported by both the receiver and the transmitter.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 6;
  localparam int unsigned CNT_W                = 14;
  localparam int unsigned DATA_BITS            = 8;
  localparam int unsigned IDX_W                = $clog2(DATA_BITS);

  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_state_t;

  // Counter target for the start-bit check: mid-bit, counted from state entry.
  function automatic logic [CNT_W-1:0] half_target(input int unsigned cpb);
    return CNT_W'(cpb / 2 - 1);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchroniser and bit-timing counter for the UART receiver.
// The counter restarts on request from the FSM and after every sample event.
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  input  logic             clear,
  input  logic [CNT_W-1:0] target,
  output logic             rx_s,
  output logic             tick
);

  logic             rx_m;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Sample counter: cleared on state entry and on each event so every bit period restarts at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Sample event when the counter reaches the target of the current state.
  always_comb begin
    tick = (cnt == target);
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start validation at mid-bit, centre sampling of data
// bits, stop-bit check, and valid/ack delivery with overrun detection.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun_err
);

  localparam logic [CNT_W-1:0] START_TGT = half_target(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_TGT   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

  uart_state_t          state;
  uart_state_t          state_next;
  logic                 rx_s;
  logic                 tick;
  logic                 cnt_clear;
  logic [CNT_W-1:0]     target;
  logic [DATA_BITS-1:0] shift;
  logic [IDX_W-1:0]     bit_idx;
  logic                 byte_good;
  logic                 stop_bad;

  uart_rx_sampler u_sampler (
    .clk    (clk),
    .reset  (reset),
    .rx     (rx),
    .clear  (cnt_clear),
    .target (target),
    .rx_s   (rx_s),
    .tick   (tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic, per-state counter target and frame completion strobes.
  always_comb begin
    state_next = state;
    target     = BIT_TGT;
    byte_good  = 1'b0;
    stop_bad   = 1'b0;
    unique case (state)
      IDLE: begin
        if (rx_s == START_LEVEL) state_next = START;
      end
      START: begin
        target = START_TGT;
        if (tick) state_next = (rx_s == START_LEVEL) ? DATA : IDLE;
      end
      DATA: begin
        if (tick && (bit_idx == LAST_IDX)) state_next = STOP;
      end
      STOP: begin
        if (tick) begin
          if (rx_s == STOP_LEVEL) begin
            byte_good  = 1'b1;
            state_next = IDLE;
          end else begin
            stop_bad   = 1'b1;
            state_next = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_s == STOP_LEVEL) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Holding the counter clear in IDLE guarantees START begins counting from 0.
    cnt_clear = (state == IDLE) || (state_next != state);
  end

  // Data shift register (LSB first) and bit index.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift   <= '0;
      bit_idx <= '0;
    end else begin
      if (state == START) bit_idx <= '0;
      if ((state == DATA) && tick) begin
        shift   <= {rx_s, shift[DATA_BITS-1:1]};
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  // Output registers: handshake, busy flag and one-cycle error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_busy     <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      rx_busy     <= (state_next == START) || (state_next == DATA) || (state_next == STOP);
      frame_err   <= stop_bad;
      overrun_err <= byte_good && rx_valid && !rx_ack;
      if (byte_good) begin
        // An ack in the completion cycle frees the slot for the new byte.
        if (!rx_valid || rx_ack) begin
          rx_data  <= shift;
          rx_valid <= 1'b1;
        end
      end else if (rx_valid && rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at CLKS_PER_BIT=6.
module tb_uart_rx;

  localparam int unsigned CPB = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun_err;

  int checks = 0;
  int errors = 0;

  int         cyc = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         rise_cyc = 0;
  int         start_cyc = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] got_q[$];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .rx_ack      (rx_ack),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_busy     (rx_busy),
    .frame_err   (frame_err),
    .overrun_err (overrun_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder: error pulse cycles, rx_valid rising edges and the byte delivered.
  always @(negedge clk) begin
    if (frame_err) fe_cnt = fe_cnt + 1;
    if (overrun_err) ov_cnt = ov_cnt + 1;
    if (rx_valid && !prev_valid) begin
      rise_cyc = cyc;
      got_q.push_back(rx_data);
    end
    prev_valid = rx_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one full frame; the first edge after the start-bit drive is edge 1,
  // and the task returns 1 time unit after edge 10*CPB.
  task automatic send_frame(input logic [7:0] b, input logic stop_lvl);
    start_cyc = cyc;
    rx = 1'b0;
    step(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      step(CPB);
    end
    rx = stop_lvl;
    step(CPB);
  endtask

  task automatic ack_once();
    rx_ack = 1'b1;
    step(1);
    rx_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx = 1'b1;
    rx_ack = 1'b0;
    step(3);
    checks++;
    if (rx_data !== 8'h00) begin
      errors++; $display("FAIL reset_data: got %0h expected 0", rx_data);
    end
    checks++;
    if ({rx_valid, rx_busy, frame_err, overrun_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {rx_valid, rx_busy, frame_err, overrun_err});
    end
    reset = 1'b0;
    step(4);
  endtask

  task automatic test_basic_frame();
    int n0, fe0, ov0;
    n0 = got_q.size(); fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'hA5, 1'b1);
    step(2);
    checks++;
    if (got_q.size() != n0 + 1 || got_q[n0] !== 8'hA5) begin
      errors++; $display("FAIL a5_delivered: got %0d bytes expected %0d", got_q.size() - n0, 1);
    end
    checks++;
    if (rx_data !== 8'hA5 || rx_valid !== 1'b1) begin
      errors++; $display("FAIL a5_outputs: got data %0h valid %b expected a5 1", rx_data, rx_valid);
    end
    // rx_s goes low 2 edges after the drive, rx_valid 58 cycles after that.
    checks++;
    if (rise_cyc - start_cyc != 60) begin
      errors++; $display("FAIL a5_latency: got %0d expected 60", rise_cyc - start_cyc);
    end
    checks++;
    if (fe_cnt != fe0 || ov_cnt != ov0) begin
      errors++; $display("FAIL a5_no_err: got fe %0d ov %0d expected 0 0", fe_cnt - fe0, ov_cnt - ov0);
    end
    ack_once();
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++; $display("FAIL ack_clears: got %b expected 0", rx_valid);
    end
    ack_once();
    checks++;
    if (rx_valid !== 1'b0 || rx_data !== 8'hA5) begin
      errors++; $display("FAIL ack_idle_ignored: got valid %b data %0h expected 0 a5", rx_valid, rx_data);
    end
  endtask

  task automatic test_back_to_back();
    int n0, fe0, ov0, gap;
    n0 = got_q.size(); fe0 = fe_cnt; ov0 = ov_cnt; gap = 0;
    fork
      begin
        send_frame(8'h3C, 1'b1);
        send_frame(8'hFF, 1'b1);
      end
      begin
        for (int k = 0; k < 2; k++) begin
          int w;
          w = 0;
          while (!rx_valid && w < 300) begin
            step(1);
            w++;
          end
          if (w >= 300) begin
            checks++; errors++;
            $display("FAIL b2b_valid_timeout: got no rx_valid expected rx_valid within 300 cycles");
          end
          step(1);
          ack_once();
        end
      end
      begin
        int w;
        w = 0;
        while (!rx_busy && w < 100) begin step(1); w++; end
        while (rx_busy && w < 400) begin step(1); w++; end
        while (!rx_busy && gap < 50) begin step(1); gap++; end
      end
    join
    step(3);
    checks++;
    if (got_q.size() != n0 + 2 || got_q[n0] !== 8'h3C || got_q[n0+1] !== 8'hFF) begin
      errors++; $display("FAIL b2b_order: got %0d bytes expected 2 (3c then ff)", got_q.size() - n0);
    end
    checks++;
    if (gap < 1 || gap > 4) begin
      errors++; $display("FAIL b2b_busy_gap: got %0d expected 1..4", gap);
    end
    checks++;
    if (fe_cnt != fe0 || ov_cnt != ov0 || rx_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_clean: got fe %0d ov %0d valid %b expected 0 0 0", fe_cnt - fe0, ov_cnt - ov0, rx_valid);
    end
  endtask

  task automatic test_glitch();
    int n0, fe0;
    n0 = got_q.size(); fe0 = fe_cnt;
    rx = 1'b0;
    step(2);
    rx = 1'b1;
    step(2);
    checks++;
    if (rx_busy !== 1'b1) begin
      errors++; $display("FAIL glitch_start_seen: got busy %b expected 1", rx_busy);
    end
    step(10);
    checks++;
    if (rx_busy !== 1'b0 || rx_valid !== 1'b0 || fe_cnt != fe0 || got_q.size() != n0) begin
      errors++; $display("FAIL glitch_rejected: got busy %b valid %b fe %0d expected 0 0 0", rx_busy, rx_valid, fe_cnt - fe0);
    end
  endtask

  task automatic test_frame_error();
    int n0, fe0;
    n0 = got_q.size(); fe0 = fe_cnt;
    send_frame(8'h55, 1'b0);
    step(20);
    checks++;
    if (fe_cnt != fe0 + 1) begin
      errors++; $display("FAIL ferr_pulse: got %0d expected 1", fe_cnt - fe0);
    end
    checks++;
    if (rx_valid !== 1'b0 || rx_busy !== 1'b0 || got_q.size() != n0) begin
      errors++; $display("FAIL ferr_break: got valid %b busy %b expected 0 0", rx_valid, rx_busy);
    end
    rx = 1'b1;
    step(CPB);
    send_frame(8'h81, 1'b1);
    step(2);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h81 || fe_cnt != fe0 + 1) begin
      errors++; $display("FAIL ferr_recover: got valid %b data %0h expected 1 81", rx_valid, rx_data);
    end
    ack_once();
  endtask

  task automatic test_overrun();
    int n0, ov0;
    ov0 = ov_cnt;
    send_frame(8'h12, 1'b1);
    step(CPB);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h12) begin
      errors++; $display("FAIL ovr_first: got valid %b data %0h expected 1 12", rx_valid, rx_data);
    end
    send_frame(8'h34, 1'b1);
    step(2);
    checks++;
    if (ov_cnt != ov0 + 1 || rx_data !== 8'h12 || rx_valid !== 1'b1) begin
      errors++; $display("FAIL ovr_pulse: got ov %0d data %0h expected 1 12", ov_cnt - ov0, rx_data);
    end
    // Ack lands in the stop-sample cycle (edge 59 .. 60 of the frame).
    ov0 = ov_cnt; n0 = got_q.size();
    fork
      send_frame(8'h34, 1'b1);
      begin
        step(59);
        rx_ack = 1'b1;
        step(1);
        rx_ack = 1'b0;
      end
    join
    step(2);
    checks++;
    if (rx_data !== 8'h34 || rx_valid !== 1'b1 || ov_cnt != ov0) begin
      errors++; $display("FAIL ovr_ack_same_cycle: got data %0h valid %b ov %0d expected 34 1 0", rx_data, rx_valid, ov_cnt - ov0);
    end
    checks++;
    if (got_q.size() != n0) begin
      errors++; $display("FAIL ovr_valid_held: got %0d valid rises expected 0", got_q.size() - n0);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] v;
    v = 8'h9C;
    rx = 1'b0;
    step(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = v[i];
      step(CPB);
    end
    rx = v[4];
    step(1);
    checks++;
    if (rx_busy !== 1'b1) begin
      errors++; $display("FAIL rst_mid_busy: got %b expected 1", rx_busy);
    end
    reset = 1'b1;
    step(1);
    checks++;
    if ({rx_data, rx_valid, rx_busy, frame_err, overrun_err} !== 12'h000) begin
      errors++; $display("FAIL rst_mid_clear: got data %0h flags %b expected 00 0000", rx_data, {rx_valid, rx_busy, frame_err, overrun_err});
    end
    reset = 1'b0;
    rx = 1'b1;
    step(2 * CPB);
    send_frame(8'h9C, 1'b1);
    step(2);
    checks++;
    if (rx_data !== 8'h9C || rx_valid !== 1'b1) begin
      errors++; $display("FAIL rst_mid_fresh: got data %0h valid %b expected 9c 1", rx_data, rx_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
